// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage of the RV32 pipeline.
// Drives the data-memory bus through a req/ack handshake, places store data
// on the correct byte lanes, formats load data, and stalls the upstream
// stages until the access completes, faults or times out.
module mem_access_stage #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [31:0] ex_mem_alu_result,
   input  logic        ex_mem_mem_read,
   input  logic        ex_mem_mem_write,
   input  logic [31:0] ex_mem_mem_write_data,
   input  logic [2:0]  ex_mem_funct3,
   output logic        mem_stall,
   output logic [31:0] mem_rdata,
   output logic        mem_done,
   output logic        mem_misaligned,
   output logic        mem_fault,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack
);

   typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, DONE = 2'd2} state_t;

   // Counter value on the last BUS cycle before the access is abandoned.
   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t      state, state_next;
   logic [15:0] cnt;
   logic [2:0]  f3_q;    // size/sign of the access in flight
   logic [1:0]  lsb_q;   // byte offset of the access in flight

   logic        access;
   logic        illegal;
   logic        misaligned;
   logic        timeout;
   logic [3:0]  be_w;
   logic [31:0] wdata_w;

   assign access  = ex_mem_mem_read | ex_mem_mem_write;
   assign timeout = (cnt == CNT_LAST);

   // Picks the addressed byte/half out of the bus word and extends it.
   function automatic logic [31:0] fmt_load(input logic [2:0]  f3,
                                            input logic [1:0]  lsb,
                                            input logic [31:0] w);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[{lsb, 3'b000} +: 8];
      h = w[{lsb[1], 4'b0000} +: 16];
      case (f3)
         3'b000:  return {{24{b[7]}}, b};
         3'b100:  return {24'h0, b};
         3'b001:  return {{16{h[15]}}, h};
         3'b101:  return {16'h0, h};
         default: return w;
      endcase
   endfunction

   // Classify the request and build lane-replicated store data and enables.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
      illegal    = 1'b0;
      misaligned = 1'b0;
      be_w       = 4'b1111;
      wdata_w    = ex_mem_mem_write_data;
      if ((ex_mem_funct3 == 3'b011) || (ex_mem_funct3 == 3'b110) ||
          (ex_mem_funct3 == 3'b111) || (ex_mem_mem_write && ex_mem_funct3[2]))
         illegal = 1'b1;
      if ((ex_mem_funct3[1:0] == 2'b01 && ex_mem_alu_result[0]) ||
          (ex_mem_funct3[1:0] == 2'b10 && ex_mem_alu_result[1:0] != 2'b00))
         misaligned = 1'b1;
      case (ex_mem_funct3[1:0])
         2'b00: begin
            be_w    = 4'b0001 << ex_mem_alu_result[1:0];
            wdata_w = {4{ex_mem_mem_write_data[7:0]}};
         end
         2'b01: begin
            be_w    = 4'b0011 << ex_mem_alu_result[1:0];
            wdata_w = {2{ex_mem_mem_write_data[15:0]}};
         end
         default: ;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      else       state <= state_next;
   end

   // Next state and the combinational stall.
   always_comb begin
      state_next = state;
      mem_stall  = 1'b0;
      case (state)
         IDLE: if (access) begin
            mem_stall  = 1'b1;
            state_next = (illegal || misaligned) ? DONE : BUS;
         end
         BUS: begin
            mem_stall = 1'b1;
            if (dmem_ack || timeout) state_next = DONE;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Bus outputs, timeout counter and registered results.
   always_ff @(posedge clk or negedge rstn) begin
      // NOTE: every register here is reset, including the bus outputs, so a reset mid-access drops dmem_req at once.
      if (!rstn) begin
         mem_rdata      <= 32'h0;
         mem_done       <= 1'b0;
         mem_misaligned <= 1'b0;
         mem_fault      <= 1'b0;
         dmem_req       <= 1'b0;
         dmem_we        <= 1'b0;
         dmem_addr      <= 32'h0;
         dmem_be        <= 4'b0000;
         dmem_wdata     <= 32'h0;
         cnt            <= 16'h0;
         f3_q           <= 3'b000;
         lsb_q          <= 2'b00;
      end else begin
         // Result flags live only in the DONE cycle.
         mem_done       <= 1'b0;
         mem_misaligned <= 1'b0;
         mem_fault      <= 1'b0;
         case (state)
            IDLE: if (access) begin
               if (illegal) begin
                  mem_done  <= 1'b1;
                  mem_fault <= 1'b1;
               end else if (misaligned) begin
                  mem_done       <= 1'b1;
                  mem_misaligned <= 1'b1;
               end else begin
                  dmem_req   <= 1'b1;
                  dmem_we    <= ex_mem_mem_write;
                  dmem_addr  <= {ex_mem_alu_result[31:2], 2'b00};
                  dmem_be    <= ex_mem_mem_write ? be_w : 4'b0000;
                  dmem_wdata <= wdata_w;
                  cnt        <= 16'h0;
                  f3_q       <= ex_mem_funct3;
                  lsb_q      <= ex_mem_alu_result[1:0];
               end
            end
            BUS: begin
               if (dmem_ack) begin
                  dmem_req <= 1'b0;
                  mem_done <= 1'b1;
                  if (!dmem_we) mem_rdata <= fmt_load(f3_q, lsb_q, dmem_rdata);
               end else if (timeout) begin
                  dmem_req  <= 1'b0;
                  mem_done  <= 1'b1;
                  mem_fault <= 1'b1;
                  mem_rdata <= 32'h0;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage: table of single accesses with
// hand-computed results, plus reset, stray-ack and mid-access reset sequences.
module tb_mem_access_stage;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [31:0] ex_mem_alu_result = '0;
   logic        ex_mem_mem_read = 1'b0;
   logic        ex_mem_mem_write = 1'b0;
   logic [31:0] ex_mem_mem_write_data = '0;
   logic [2:0]  ex_mem_funct3 = '0;
   logic        mem_stall;
   logic [31:0] mem_rdata;
   logic        mem_done;
   logic        mem_misaligned;
   logic        mem_fault;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata = '0;
   logic        dmem_ack = 1'b0;

   mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
      .clk                   (clk),
      .rstn                  (rstn),
      .ex_mem_alu_result     (ex_mem_alu_result),
      .ex_mem_mem_read       (ex_mem_mem_read),
      .ex_mem_mem_write      (ex_mem_mem_write),
      .ex_mem_mem_write_data (ex_mem_mem_write_data),
      .ex_mem_funct3         (ex_mem_funct3),
      .mem_stall             (mem_stall),
      .mem_rdata             (mem_rdata),
      .mem_done              (mem_done),
      .mem_misaligned        (mem_misaligned),
      .mem_fault             (mem_fault),
      .dmem_req              (dmem_req),
      .dmem_we               (dmem_we),
      .dmem_addr             (dmem_addr),
      .dmem_be               (dmem_be),
      .dmem_wdata            (dmem_wdata),
      .dmem_rdata            (dmem_rdata),
      .dmem_ack              (dmem_ack)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // One access: inputs, bus behaviour (ack after 'waits' no-ack BUS cycles)
   // and the expected outcome.
   typedef struct {
      logic        rd;
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] rdat;
      int          waits;
      int          exp_stall;
      int          exp_req;
      logic [3:0]  exp_be;
      logic [31:0] exp_wdata;
      logic [31:0] exp_rdata;
      logic        exp_mis;
      logic        exp_fault;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rd, input logic wr, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdat,
                      input int waits, input int st, input int rq, input logic [3:0] be,
                      input logic [31:0] ewd, input logic [31:0] erd,
                      input logic mis, input logic flt);
      vec_t v;
      v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wd = wd; v.rdat = rdat;
      v.waits = waits; v.exp_stall = st; v.exp_req = rq; v.exp_be = be;
      v.exp_wdata = ewd; v.exp_rdata = erd; v.exp_mis = mis; v.exp_fault = flt;
      vecs.push_back(v);
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int          stall_n = 0;
      int          req_n = 0;
      int          unstable = 0;
      bit          done_seen = 0;
      logic [31:0] a0 = '0;
      logic [31:0] w0 = '0;
      logic [3:0]  b0 = '0;
      logic        we0 = 1'b0;
      @(posedge clk); #1;
      ex_mem_mem_read = v.rd;  ex_mem_mem_write = v.wr;  ex_mem_funct3 = v.f3;
      ex_mem_alu_result = v.addr;  ex_mem_mem_write_data = v.wd;  dmem_ack = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (mem_done) begin
            done_seen = 1;
            break;
         end
         if (mem_stall) stall_n++;
         dmem_ack = 1'b0;
         if (dmem_req) begin
            req_n++;
            if (req_n == 1) begin
               a0 = dmem_addr; w0 = dmem_wdata; b0 = dmem_be; we0 = dmem_we;
            end else if (a0 !== dmem_addr || w0 !== dmem_wdata || b0 !== dmem_be || we0 !== dmem_we) begin
               unstable++;
            end
            if (req_n == v.waits + 1) begin
               dmem_ack = 1'b1;
               dmem_rdata = v.rdat;
            end
         end
      end
      check($sformatf("v%0d done", idx), 32'(done_seen), 32'd1);
      check($sformatf("v%0d stall_cycles", idx), stall_n, v.exp_stall);
      check($sformatf("v%0d req_cycles", idx), req_n, v.exp_req);
      check($sformatf("v%0d stall_in_done", idx), 32'(mem_stall), 32'd0);
      check($sformatf("v%0d misaligned", idx), 32'(mem_misaligned), 32'(v.exp_mis));
      check($sformatf("v%0d fault", idx), 32'(mem_fault), 32'(v.exp_fault));
      check($sformatf("v%0d rdata", idx), mem_rdata, v.exp_rdata);
      if (v.exp_req > 0) begin
         check($sformatf("v%0d addr", idx), a0, v.addr & 32'hFFFF_FFFC);
         check($sformatf("v%0d be", idx), 32'(b0), 32'(v.exp_be));
         check($sformatf("v%0d we", idx), 32'(we0), 32'(v.wr));
         check($sformatf("v%0d req_stable", idx), unstable, 0);
         if (v.wr) check($sformatf("v%0d wdata", idx), w0, v.exp_wdata);
      end
      ex_mem_mem_read = 1'b0;  ex_mem_mem_write = 1'b0;  dmem_ack = 1'b0;
      @(negedge clk);
      check($sformatf("v%0d flags_clear", idx),
            {29'h0, mem_done, mem_misaligned, mem_fault}, 32'h0);
      check($sformatf("v%0d idle_stall", idx), 32'(mem_stall), 32'd0);
   endtask

   initial begin
      //  rd wr f3      addr          wd             rdat          wt st rq be       exp_wdata      exp_rdata     mis flt
      add(1, 0, 3'b010, 32'h100, 32'h0,         32'hDEADBEEF, 0, 2, 1, 4'b0000, 32'h0,         32'hDEADBEEF, 0, 0); // LW
      add(1, 0, 3'b000, 32'h203, 32'h0,         32'h80FF1234, 0, 2, 1, 4'b0000, 32'h0,         32'hFFFFFF80, 0, 0); // LB
      add(1, 0, 3'b100, 32'h203, 32'h0,         32'h80FF1234, 0, 2, 1, 4'b0000, 32'h0,         32'h00000080, 0, 0); // LBU
      add(1, 0, 3'b001, 32'h202, 32'h0,         32'h80FF1234, 0, 2, 1, 4'b0000, 32'h0,         32'hFFFF80FF, 0, 0); // LH
      add(1, 0, 3'b101, 32'h202, 32'h0,         32'h80FF1234, 0, 2, 1, 4'b0000, 32'h0,         32'h000080FF, 0, 0); // LHU
      add(1, 0, 3'b000, 32'h200, 32'h0,         32'h80FF1234, 1, 3, 2, 4'b0000, 32'h0,         32'h00000034, 0, 0); // LB, 1 wait
      add(0, 1, 3'b000, 32'h011, 32'h000000AB,  32'hFFFFFFFF, 0, 2, 1, 4'b0010, 32'hABABABAB,  32'h00000034, 0, 0); // SB
      add(0, 1, 3'b001, 32'h012, 32'h00001234,  32'hFFFFFFFF, 3, 5, 4, 4'b1100, 32'h12341234,  32'h00000034, 0, 0); // SH, 3 waits
      add(0, 1, 3'b010, 32'h020, 32'hCAFEF00D,  32'hFFFFFFFF, 0, 2, 1, 4'b1111, 32'hCAFEF00D,  32'h00000034, 0, 0); // SW
      add(1, 0, 3'b010, 32'h102, 32'h0,         32'h0,        0, 1, 0, 4'b0000, 32'h0,         32'h00000034, 1, 0); // LW misaligned
      add(1, 0, 3'b001, 32'h201, 32'h0,         32'h0,        0, 1, 0, 4'b0000, 32'h0,         32'h00000034, 1, 0); // LH misaligned
      add(1, 0, 3'b011, 32'h100, 32'h0,         32'h0,        0, 1, 0, 4'b0000, 32'h0,         32'h00000034, 0, 1); // funct3 011
      add(0, 1, 3'b100, 32'h100, 32'h0,         32'h0,        0, 1, 0, 4'b0000, 32'h0,         32'h00000034, 0, 1); // store BU
      add(1, 1, 3'b010, 32'h040, 32'h11223344,  32'hFFFFFFFF, 0, 2, 1, 4'b1111, 32'h11223344,  32'h00000034, 0, 0); // rd+wr -> write
      add(1, 0, 3'b010, 32'h300, 32'h0,         32'h0,        99, 5, 4, 4'b0000, 32'h0,        32'h00000000, 0, 1); // timeout
      add(1, 0, 3'b010, 32'h104, 32'h0,         32'h01234567, 0, 2, 1, 4'b0000, 32'h0,         32'h01234567, 0, 0); // after timeout

      // Reset state.
      #12;
      check("reset req", 32'(dmem_req), 32'd0);
      check("reset stall", 32'(mem_stall), 32'd0);
      check("reset outputs", {dmem_addr | dmem_wdata | mem_rdata},  32'h0);
      check("reset flags", {26'h0, dmem_be, mem_done, mem_fault}, 32'h0);
      @(negedge clk);
      rstn = 1'b1;

      // A stray ack while idle does nothing.
      @(negedge clk);
      dmem_ack = 1'b1;  dmem_rdata = 32'h5555_5555;
      @(negedge clk);
      check("idle_ack done", 32'(mem_done), 32'd0);
      check("idle_ack rdata", mem_rdata, 32'h0);
      dmem_ack = 1'b0;

      for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

      // Reset in the middle of a bus access.
      @(posedge clk); #1;
      ex_mem_mem_read = 1'b1;  ex_mem_funct3 = 3'b010;  ex_mem_alu_result = 32'h500;
      @(negedge clk);
      @(negedge clk);
      check("midrst req_before", 32'(dmem_req), 32'd1);
      #2;
      rstn = 1'b0;  ex_mem_mem_read = 1'b0;
      #1;
      check("midrst req_after", 32'(dmem_req), 32'd0);
      check("midrst stall", 32'(mem_stall), 32'd0);
      check("midrst outputs", {dmem_addr | mem_rdata}, 32'h0);
      @(negedge clk);
      rstn = 1'b1;
      dmem_ack = 1'b1;  dmem_rdata = 32'h7777_7777;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check($sformatf("late_ack done c%0d", c), {30'h0, mem_done, dmem_req}, 32'h0);
      end
      dmem_ack = 1'b0;
      check("late_ack rdata", mem_rdata, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
